// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors match controller: result codes,
// winner encoding, FSM states and the round-limit tie-break helper.
package rps_pkg;

   typedef enum logic [1:0] {
      RES_TIE = 2'b00,
      RES_P1  = 2'b01,
      RES_P2  = 2'b10,
      RES_ILL = 2'b11
   } res_code_e;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10,
      WIN_DRAW = 2'b11
   } winner_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam logic [7:0] CNT_MAX = 8'hFF;

   // Verdict when the round limit ends a match with nobody at the win target.
   function automatic winner_e limit_winner(input logic [7:0] s1, input logic [7:0] s2);
      winner_e w;
      if (s1 > s2) begin
         w = WIN_P1;
      end else if (s2 > s1) begin
         w = WIN_P2;
      end else begin
         w = WIN_DRAW;
      end
      return w;
   endfunction

endpackage

// File: rtl/rps_sat_cnt.sv
// 8-bit up-counter with synchronous clear (priority), enable and saturation
// at 255; asynchronously zeroed by the active-low reset.
module rps_sat_cnt
   import rps_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       en_i,
   output logic [7:0] cnt_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Next count: clear wins over increment, increment stops at full scale.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 8'd0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/rps_match_ctrl.sv
// Rock-paper-scissors match controller: accepts round results in PLAY,
// keeps per-match tallies and reports the match verdict in DONE until ack.
module rps_match_ctrl
   import rps_pkg::*;
#(
   parameter int WINS_TO_MATCH = 3,
   parameter int MAX_ROUNDS    = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       res_valid,
   input  logic [1:0] res_code,
   output logic       res_ready,
   output logic [7:0] score1,
   output logic [7:0] score2,
   output logic [7:0] ties,
   output logic [7:0] round_cnt,
   output logic [7:0] err_cnt,
   output logic       match_done,
   output logic [1:0] match_winner,
   input  logic       ack
);

   localparam logic [7:0] WINS_C = 8'(WINS_TO_MATCH);
   localparam logic [7:0] MAX_C  = 8'(MAX_ROUNDS);

   state_e     state_q, state_d;
   winner_e    winner_q, winner_d;
   res_code_e  code_s;
   logic       acc_s, clr_s;
   logic       p1_en_s, p2_en_s, tie_en_s, rnd_en_s, err_en_s;
   logic [7:0] s1_nx_s, s2_nx_s, rnd_nx_s;

   assign code_s = res_code_e'(res_code);

   // Acceptance decode, look-ahead tallies and next-state/verdict selection.
   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      clr_s    = 1'b0;
      acc_s    = res_valid && (state_q == ST_PLAY);
      p1_en_s  = acc_s && (code_s == RES_P1);
      p2_en_s  = acc_s && (code_s == RES_P2);
      tie_en_s = acc_s && (code_s == RES_TIE);
      err_en_s = acc_s && (code_s == RES_ILL);
      rnd_en_s = p1_en_s || p2_en_s || tie_en_s;
      s1_nx_s  = score1 + {7'd0, p1_en_s};
      s2_nx_s  = score2 + {7'd0, p2_en_s};
      rnd_nx_s = round_cnt + {7'd0, rnd_en_s};
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_PLAY;
               clr_s    = 1'b1;
               winner_d = WIN_NONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PLAY: begin
            // A player reaching the win target outranks the round limit.
            if (acc_s && (s1_nx_s == WINS_C)) begin
               state_d  = ST_DONE;
               winner_d = WIN_P1;
            end else if (acc_s && (s2_nx_s == WINS_C)) begin
               state_d  = ST_DONE;
               winner_d = WIN_P2;
            end else if (acc_s && (rnd_nx_s == MAX_C)) begin
               state_d  = ST_DONE;
               winner_d = limit_winner(s1_nx_s, s2_nx_s);
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_DONE: begin
            if (ack) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            winner_d = WIN_NONE;
         end
      endcase
   end

   // FSM state and verdict registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         winner_q <= WIN_NONE;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
      end
   end

   rps_sat_cnt u_score1 (.clk(clk), .rst(rst), .clr_i(clr_s), .en_i(p1_en_s),  .cnt_o(score1));
   rps_sat_cnt u_score2 (.clk(clk), .rst(rst), .clr_i(clr_s), .en_i(p2_en_s),  .cnt_o(score2));
   rps_sat_cnt u_ties   (.clk(clk), .rst(rst), .clr_i(clr_s), .en_i(tie_en_s), .cnt_o(ties));
   rps_sat_cnt u_rounds (.clk(clk), .rst(rst), .clr_i(clr_s), .en_i(rnd_en_s), .cnt_o(round_cnt));
   // Illegal-code count spans matches, so it is only ever cleared by reset.
   rps_sat_cnt u_errs   (.clk(clk), .rst(rst), .clr_i(1'b0),  .en_i(err_en_s), .cnt_o(err_cnt));

   assign res_ready    = (state_q == ST_PLAY);
   assign match_done   = (state_q == ST_DONE);
   assign match_winner = winner_q;

endmodule
